mem_wb_stage_reg: RTL

//  MEM->WB pipeline register with memory-wait handling. Sits between the MEM stage and the
//  WB stage. Latches the MEM stage's result only once that stage reports ready for loads and

---
 rtl/mem_wb_stage_reg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage_reg.sv
// mem_wb_stage_reg
// MEM->WB pipeline register with memory-wait handling.
// This block captures the MEM-stage result into the WB registers once the access
// completes. While a load or store is still outstanding, it injects WB bubbles
// and raises freeze. It also sets a sticky flag for an access that waits too long.
// Optional feature: define MEM_WB_STALL_CNT_EN to build the 32-bit stall counter.
// Otherwise stall_count is tied to 0.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   valid_in       EXE/MEM register holds a real instruction
//   WB_EN_in       instruction writes the register file
//   MEM_R_EN_in    load
//   MEM_W_EN_in    store
//   ALU_result_in  address / ALU value
//   Mem_read_value load data, meaningful together with mem_ready
//   Dest_in        destination register index
//   mem_ready      MEM stage access complete
//   WB_EN          registered write enable
//   WB_Dest        registered destination
//   WB_Value       registered value (load data for loads, else ALU result)
//   freeze         combinational pipeline hold for this cycle
//   mem_timeout    sticky: an access waited TIMEOUT_CYC cycles
//   stall_count    number of frozen cycles (0 unless the counter is built)
//   state_dbg      FSM state: 0 = PASS, 1 = WAIT
//
// Handshake: a memory op (valid_in & (load | store)) is accepted on the edge
// where mem_ready is 1. Until then, freeze stays high and the EXE/MEM inputs
// are held stable upstream. A mem_ready seen with no memory op pending is
// ignored.
module mem_wb_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int DEST_W      = 5,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Mem_read_value,
  input  logic [DEST_W-1:0] Dest_in,
  input  logic              mem_ready,
  output logic              WB_EN,
  output logic [DEST_W-1:0] WB_Dest,
  output logic [DATA_W-1:0] WB_Value,
  output logic              freeze,
  output logic              mem_timeout,
  output logic [31:0]       stall_count,
  output logic              state_dbg
);

  typedef enum logic {PASS = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT_CYC);

  state_t            state;
  logic [15:0]       wait_cnt;
  logic              mem_op;
  logic              mem_wb_en;
  logic [DATA_W-1:0] mem_value;
  logic [16:0]       wait_cnt_inc;

  assign mem_op       = valid_in & (MEM_R_EN_in | MEM_W_EN_in);
  // Stores never write back. A load returns memory data.
  assign mem_wb_en    = WB_EN_in & MEM_R_EN_in;
  assign mem_value    = MEM_R_EN_in ? Mem_read_value : ALU_result_in;
  assign wait_cnt_inc = {1'b0, wait_cnt} + 17'd1;
  assign state_dbg    = state;

  // freeze is forced low while reset is asserted, so a reset in WAIT
  // releases the pipeline at once.
  always_comb begin
    freeze = 1'b0;
    if (rst) begin
      case (state)
        PASS:    freeze = mem_op & ~mem_ready;
        WAIT:    freeze = ~mem_ready;
        default: freeze = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= PASS;
      wait_cnt    <= '0;
      WB_EN       <= 1'b0;
      WB_Dest     <= '0;
      WB_Value    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        PASS: begin
          if (!mem_op) begin
            WB_EN    <= valid_in & WB_EN_in;
            WB_Dest  <= Dest_in;
            WB_Value <= ALU_result_in;
          end else if (mem_ready) begin
            WB_EN    <= mem_wb_en;
            WB_Dest  <= Dest_in;
            WB_Value <= mem_value;
          end else begin
            WB_EN    <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            WB_EN    <= mem_wb_en;
            WB_Dest  <= Dest_in;
            WB_Value <= mem_value;
            state    <= PASS;
          end else begin
            WB_EN <= 1'b0;
            if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt_inc[15:0];
            // Flag on the edge the count reaches the limit. The FSM keeps waiting.
            if (wait_cnt_inc >= TIMEOUT_L) mem_timeout <= 1'b1;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

`ifdef MEM_WB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_count <= '0;
    else if (freeze) stall_count <= stall_count + 32'd1;
  end
`else
  assign stall_count = '0;
`endif

endmodule
